// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder controller: sequences two W-bit operands one nibble per cycle
// through an external 4-bit parallel adder and presents the W-bit sum with carry-out.
module nibble_serial_add_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 op_cin,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_sum,
  input  logic                 add_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] result,
  output logic                 result_cout
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t          state, state_nx;
  logic [W-1:0]    a_q, b_q, res_q;
  logic            carry_q;
  logic [IW-1:0]   idx_q;
  logic            last;
  logic [3:0]      nib_a, nib_b;

  assign last = (idx_q == IW'(NIBBLES - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nx = ADD;
      ADD:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // Nibble mux is driven only from registered operands and index
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx_q == IW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  always_comb begin
    in_ready    = (state == IDLE);
    out_valid   = (state == DONE);
    add_a       = '0;
    add_b       = '0;
    add_cin     = 1'b0;
    if (state == ADD) begin
      add_a   = nib_a;
      add_b   = nib_b;
      add_cin = carry_q;
    end
    result      = res_q;
    result_cout = carry_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= op_a;
            b_q     <= op_b;
            carry_q <= op_cin;
            idx_q   <= '0;
          end
        end
        ADD: begin
          for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (idx_q == IW'(i)) res_q[4*i +: 4] <= add_sum;
          end
          carry_q <= add_cout;
          if (!last) idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl (NIBBLES=4) with a 4-bit adder model
// on the add_* port and a queue scoreboard checked at each result handshake.
module tb_nibble_serial_add_ctrl;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a, op_b;
  logic         op_cin;
  logic [3:0]   add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         result_cout;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_cout(result_cout)
  );

  logic [4:0] adder_full;
  assign adder_full = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
  assign add_sum    = adder_full[3:0];
  assign add_cout   = adder_full[4];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] res;
    logic         cout;
  } exp_t;
  exp_t sb[$];

  // Scoreboard: each result handshake must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_result", 32'(result), 32'(e.res));
        check("sb_cout", 32'(result_cout), 32'(e.cout));
      end
    end
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] res;
    logic         cout;
    int           hold;
  } vec_t;
  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input vec_t v, input bit check_seq);
    logic [3:0] seq_a[4];
    logic [3:0] seq_b[4];
    int edges;
    int waitc;
    waitc = 0;
    while (!in_ready && waitc < 20) begin step(); waitc++; end
    check("txn_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; op_a = v.a; op_b = v.b; op_cin = v.cin;
    out_ready = (v.hold == 0);
    @(posedge clk);
    sb.push_back('{res: v.res, cout: v.cout});
    #1;
    in_valid = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom); op_cin = 1'($urandom);
    edges = 0;
    while (!out_valid && edges < 20) begin
      if (edges < 4) begin seq_a[edges] = add_a; seq_b[edges] = add_b; end
      op_a = W'($urandom); op_b = W'($urandom);
      step();
      edges++;
    end
    check("latency", 32'(edges), 32'(N));
    if (check_seq) begin
      check("add_a_seq0", 32'(seq_a[0]), 32'h5);
      check("add_a_seq1", 32'(seq_a[1]), 32'hA);
      check("add_a_seq2", 32'(seq_a[2]), 32'h0);
      check("add_a_seq3", 32'(seq_a[3]), 32'h0);
      check("add_b_seq0", 32'(seq_b[0]), 32'hA);
      check("add_b_seq1", 32'(seq_b[1]), 32'h5);
    end
    for (int h = 0; h < v.hold; h++) begin
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_result", 32'(result), 32'(v.res));
      check("hold_cout", 32'(result_cout), 32'(v.cout));
      check("done_in_ready", 32'(in_ready), 32'd0);
      check("done_add_bus", 32'({add_a, add_b, add_cin}), 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    check("post_hs_in_ready", 32'(in_ready), 32'd1);
    check("post_hs_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{a: 16'h00A5, b: 16'h005A, cin: 1'b0, res: 16'h00FF, cout: 1'b0, hold: 0};
    vecs[1] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, res: 16'h0000, cout: 1'b1, hold: 0};
    vecs[2] = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, res: 16'hFFFF, cout: 1'b1, hold: 3};
    vecs[3] = '{a: 16'h1234, b: 16'h4321, cin: 1'b0, res: 16'h5555, cout: 1'b0, hold: 0};
    vecs[4] = '{a: 16'h8000, b: 16'h8000, cin: 1'b0, res: 16'h0000, cout: 1'b1, hold: 1};
    vecs[5] = '{a: 16'h0000, b: 16'h0000, cin: 1'b1, res: 16'h0001, cout: 1'b0, hold: 0};
    vecs[6] = '{a: 16'h0F0F, b: 16'h0101, cin: 1'b1, res: 16'h1011, cout: 1'b0, hold: 2};

    rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; op_cin = 1'b0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_cout", 32'(result_cout), 32'd0);
    check("rst_add_bus", 32'({add_a, add_b, add_cin}), 32'd0);

    foreach (vecs[i]) run_txn(vecs[i], i == 0);

    // Reset while idx==2 aborts; nothing pushed, so any later result is flagged
    in_valid = 1'b1; op_a = 16'h1111; op_b = 16'h2222; op_cin = 1'b0;
    step();
    in_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_cout", 32'(result_cout), 32'd0);
    for (int k = 0; k < 8; k++) begin
      check("abort_no_valid", 32'(out_valid), 32'd0);
      step();
    end

    // Back-to-back operand sets with in_valid held high
    out_ready = 1'b1;
    in_valid = 1'b1; op_a = 16'h0123; op_b = 16'h0456; op_cin = 1'b0;
    @(posedge clk);
    sb.push_back('{res: 16'h0579, cout: 1'b0});
    #1;
    op_a = 16'hF000; op_b = 16'h1000; op_cin = 1'b1;
    begin
      int waitc;
      waitc = 0;
      while (!out_valid && waitc < 20) begin
        check("b2b_busy_in_ready", 32'(in_ready), 32'd0);
        step(); waitc++;
      end
      check("b2b_first_latency", 32'(waitc), 32'(N));
    end
    check("b2b_done_in_ready", 32'(in_ready), 32'd0);
    step();
    check("b2b_idle_in_ready", 32'(in_ready), 32'd1);
    check("b2b_idle_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    sb.push_back('{res: 16'h0001, cout: 1'b1});
    #1;
    in_valid = 1'b0;
    check("b2b_second_accepted", 32'(in_ready), 32'd0);
    begin
      int waitc;
      waitc = 0;
      while (sb.size() != 0 && waitc < 30) begin step(); waitc++; end
    end
    step();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
